systolic_feeder: RTL

- Operand skew feeder that drives the west (A) and north (B) edges of an N x N pe_cell systolic array.
- Accepts one K-slice per beat over a valid/ready handshake: column k of A and row k of B.
- Delays lane i by i cycles, so operands meet diagonally inside the array.
- Generates the per-lane accumulator-clear pulses and a job-complete pulse.

---
 rtl/systolic_feeder_if.sv | 38 +++
 rtl/systolic_feeder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Handshake and edge bus between a job source and the systolic operand feeder.
// Optional member stall_cnt exists only when FEEDER_STALL_CNT_EN is defined.
interface systolic_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int KW = 5
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic [N*DW-1:0] a_edge;
  logic [N*DW-1:0] b_edge;
  logic [N-1:0]    start_edge;
  logic            busy;
  logic            done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, a_edge, b_edge, start_edge, busy, done
`ifdef FEEDER_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, a_edge, b_edge, start_edge, busy, done
`ifdef FEEDER_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand skew feeder for the west (A) and north (B) edges of an N x N array.
// Lane i is delayed by i extra cycles so operands meet diagonally; a 1-bit tag
// in the same chains marks beat 0 to clear accumulators.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating stall-cycle counter.
module systolic_feeder #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int K_MAX = 16,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);
  localparam int FW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [KW-1:0]   k_clamped;
  logic            accept;
  logic            head_tag;
  logic [N*DW-1:0] a_head;
  logic [N*DW-1:0] b_head;

  assign k_clamped = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  assign accept    = (state_q == STREAM) && bus.in_valid;
  // Non-accepted slots inject zeros: a bubble is arithmetically neutral.
  assign a_head    = accept ? bus.a_col : '0;
  assign b_head    = accept ? bus.b_row : '0;
  assign head_tag  = accept && (beat_q == '0);

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    klen_d       = klen_q;
    beat_d       = beat_q;
    flush_d      = flush_q;
    bus.busy     = 1'b0;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.k_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            klen_d  = k_clamped;
            beat_d  = '0;
          end
        end
      end
      STREAM: begin
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // Compare before incrementing so the counter never wraps at K_MAX.
          if (beat_q == klen_q - KW'(1)) begin
            state_d = FLUSH;
            flush_d = FW'(N);
          end else begin
            beat_d = beat_q + KW'(1);
          end
        end
      end
      FLUSH: begin
        bus.busy = 1'b1;
        if (flush_q == '0) begin
          state_d = DONE;
        end else begin
          flush_d = flush_q - FW'(1);
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] a_q [0:gi];
      logic [DW-1:0] b_q [0:gi];
      logic          t_q [0:gi];

      // Lane gi skew chain, gi+1 stages deep; the tail drives the array edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s <= gi; s++) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
            t_q[s] <= 1'b0;
          end
        end else begin
          a_q[0] <= a_head[gi*DW +: DW];
          b_q[0] <= b_head[gi*DW +: DW];
          t_q[0] <= head_tag;
          for (int s = 1; s <= gi; s++) begin
            a_q[s] <= a_q[s-1];
            b_q[s] <= b_q[s-1];
            t_q[s] <= t_q[s-1];
          end
        end
      end

      assign bus.a_edge[gi*DW +: DW] = a_q[gi];
      assign bus.b_edge[gi*DW +: DW] = b_q[gi];
      assign bus.start_edge[gi]      = t_q[gi];
    end
  endgenerate

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  // Counts STREAM cycles without a beat; cleared at job start, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == IDLE && state_d == STREAM) begin
      stall_q <= '0;
    end else if (state_q == STREAM && !bus.in_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule
